// File: rtl/divider_pkg.sv
// divider_pkg: shared FSM state type and counter sizing for the multicycle divider
package divider_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division step producing one quotient bit
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] p_in,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p_out,
  output logic             q_bit
);
  logic [WIDTH:0] sh, t;
  // p_in < b always holds, so the shifted value stays below 2b and t[WIDTH] is a true sign bit
  always_comb begin
    sh    = {p_in, a_bit};
    t     = sh - {1'b0, b};
    q_bit = ~t[WIDTH];
    p_out = t[WIDTH] ? sh[WIDTH-1:0] : t[WIDTH-1:0];
  end
endmodule

// File: rtl/divider_multicycle.sv
// divider_multicycle: fixed-latency radix-2 restoring divider; DIVIDER_SIGNED_EN selects two's complement operands
module divider_multicycle
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rem
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_r, b_r, dvd, p, p_nx, a_mag, b_mag;
  logic             q_bit, neg_q, neg_r;
`ifdef DIVIDER_SIGNED_EN
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
`else
  assign a_mag = a;
  assign b_mag = b;
  assign neg_q = 1'b0;
  assign neg_r = 1'b0;
`endif
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  divider_step #(.WIDTH(WIDTH)) u_step (
    .p_in  (p),
    .a_bit (dvd[WIDTH-1]),
    .b     (b_r),
    .p_out (p_nx),
    .q_bit (q_bit)
  );
  // FSM, magnitude shift registers and fix-up; dvd shifts the dividend out and the quotient in
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      q     <= '0;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= BUSY;
          a_r   <= a;
          b_r   <= b_mag;
          dvd   <= a_mag;
          p     <= '0;
          count <= CW'(WIDTH - 1);
`ifdef DIVIDER_SIGNED_EN
          neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
          neg_r <= a[WIDTH-1];
`endif
        end
        BUSY: begin
          p     <= p_nx;
          dvd   <= {dvd[WIDTH-2:0], q_bit};
          count <= count - 1'b1;
          if (count == '0) state <= FIX;
        end
        FIX: begin
          q     <= (b_r == '0) ? '1 : (neg_q ? -dvd : dvd);
          rem   <= (b_r == '0) ? a_r : (neg_r ? -p : p);
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_multicycle.sv
// tb_divider_multicycle: scoreboard bench for divider_multicycle; define DIVIDER_SIGNED_EN for the signed build
module tb_divider_multicycle;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset, in_valid, out_ready;
  logic in_ready, out_valid;
  logic [W-1:0] a, b, q, rem;
  int total = 0, bad = 0, cyc = 0, acc_cyc = 0;
  logic prev_ov = 1'b0;
  typedef struct {logic [W-1:0] q; logic [W-1:0] r;} exp_t;
  exp_t sb[$];
  divider_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .q(q), .rem(rem)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W-1:0] xm, ym;
    if (y == '0) begin
      e.q = '1;
      e.r = x;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      xm = x[W-1] ? -x : x;
      ym = y[W-1] ? -y : y;
      e.q = (x[W-1] ^ y[W-1]) ? -(xm / ym) : xm / ym;
      e.r = x[W-1] ? -(xm % ym) : xm % ym;
`else
      xm = x;
      ym = y;
      e.q = xm / ym;
      e.r = xm % ym;
`endif
    end
    return e;
  endfunction
  // Monitor: checks latency on each rising out_valid and pops the scoreboard on each handshake
  always @(negedge clk) begin
    if (reset) prev_ov <= 1'b0;
    else begin
      if (out_valid && !prev_ov) chk("latency", W'(cyc - acc_cyc), W'(W + 1));
      prev_ov <= out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("q", q, e.q);
          chk("rem", rem, e.r);
        end
      end
    end
  end
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] eq,
                       input logic [W-1:0] er, input bit push);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    e.q = eq;
    e.r = er;
    if (push) sb.push_back(e);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", W'(sb.size()), '0);
  endtask
  initial begin
    logic [W-1:0] sa, sbv;
    exp_t e;
    int n;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_q", q, 0);
    chk("rst_rem", rem, 0);
    reset = 1'b0;
    issue(100, 7, 14, 2, 1);
    issue(32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 1);
    issue(5, 9, 0, 5, 1);
    issue(123, 0, 32'hFFFF_FFFF, 123, 1);
    issue(7, 7, 1, 0, 1);
    issue(0, 5, 0, 0, 1);
`ifdef DIVIDER_SIGNED_EN
    issue(-32'sd7, 2, -32'sd3, -32'sd1, 1);
    issue(7, -32'sd2, -32'sd3, 1, 1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1);
    issue(-32'sd9, 0, 32'hFFFF_FFFF, -32'sd9, 1);
`endif
    drain();
    out_ready = 1'b0;
    issue(1000, 7, 142, 6, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_valid", W'(out_valid), 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_q", q, 142);
      chk("hold_rem", rem, 6);
      chk("hold_in_ready", W'(in_ready), 0);
      chk("hold_out_valid", W'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", W'(in_ready), 1);
    chk("release_out_valid", W'(out_valid), 0);
    issue(1000, 3, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", W'(in_ready), 1);
    chk("midrst_out_valid", W'(out_valid), 0);
    chk("midrst_q", q, 0);
    chk("midrst_rem", rem, 0);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      chk("no_stale_result", W'(out_valid), 0);
    end
    sa = 32'h1234_5678;
    sbv = 32'h0000_0003;
    for (int i = 0; i < 1000; i++) begin
      e = model(sa, sbv);
      issue(sa, sbv, e.q, e.r, 1);
      sa += 32'h2345_6789;
      sbv += 32'h3456_7891;
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
